// File: rtl/lc3_pkg.sv
// lc3_pkg: shared constants for the LC-3 execute/writeback slice.
// Instruction field positions, ALU opcodes and condition-code encodings.
package lc3_pkg;

  // Datapath sizing
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  // Opcodes handled by the execute stage
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  // Instruction field bit positions
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int DR_HI    = 11;
  localparam int DR_LO    = 9;
  localparam int SR1_HI   = 8;
  localparam int SR1_LO   = 6;
  localparam int IMM_FLAG = 5;
  localparam int IMM5_HI  = 4;
  localparam int IMM5_LO  = 0;
  localparam int SR2_HI   = 2;
  localparam int SR2_LO   = 0;

  // Condition codes {N,Z,P}
  localparam logic [2:0] NZP_N     = 3'b100;
  localparam logic [2:0] NZP_Z     = 3'b010;
  localparam logic [2:0] NZP_P     = 3'b001;
  localparam logic [2:0] NZP_RESET = NZP_Z;

  // True for the opcodes that produce a register write
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/lc3_alu.sv
// lc3_alu: combinational ADD/AND/NOT unit with condition-code generation.
module lc3_alu
  import lc3_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       nzp_o
);

  logic [WIDTH-1:0] result_s;
  logic [2:0]       nzp_s;

  // Operation select; carry out of ADD is discarded
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (opcode_i)
      OP_ADD:  result_s = a_i + b_i;
      OP_AND:  result_s = a_i & b_i;
      OP_NOT:  result_s = ~a_i;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Classify the result as negative, zero or positive
  always_comb begin
    nzp_s = NZP_P;
    if (result_s[WIDTH-1]) begin
      nzp_s = NZP_N;
    end else if (result_s == {WIDTH{1'b0}}) begin
      nzp_s = NZP_Z;
    end else begin
      nzp_s = NZP_P;
    end
  end

  assign result_o = result_s;
  assign nzp_o    = nzp_s;

endmodule

// File: rtl/lc3_execute.sv
// lc3_execute: LC-3 execute/writeback stage next to the 8x16 register file.
// Drives read addresses combinationally, computes ADD/AND/NOT and drives the
// registered write port and NZP one cycle after acceptance.
// Build option: define LC3_BYPASS_EN to forward the pending writeback into
// the operands instead of stalling on a read-after-write hazard.
module lc3_execute
  import lc3_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int RAW   = REG_AW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      ir,
  output logic [RAW-1:0]   sr1,
  output logic [RAW-1:0]   sr2,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             wr,
  output logic [RAW-1:0]   dr,
  output logic [WIDTH-1:0] din,
  output logic [2:0]       nzp,
  output logic             illegal
);

  // Decoded fields
  logic [3:0]       opcode_s;
  logic [RAW-1:0]   dst_s;
  logic             imm_flag_s;
  logic [WIDTH-1:0] imm_sext_s;
  logic             reads_sr2_s;
  logic             accept_s;
  logic             alu_op_s;

  // Operands and ALU outputs
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_reg_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] result_s;
  logic [2:0]       alu_nzp_s;
  logic             ready_s;

  // Writeback / condition-code state
  logic             wr_q,      wr_d;
  logic [RAW-1:0]   dr_q,      dr_d;
  logic [WIDTH-1:0] din_q,     din_d;
  logic [2:0]       nzp_q,     nzp_d;
  logic             illegal_q, illegal_d;

  assign opcode_s    = ir[OP_HI:OP_LO];
  assign dst_s       = ir[DR_HI:DR_LO];
  assign imm_flag_s  = ir[IMM_FLAG];
  assign imm_sext_s  = {{(WIDTH-5){ir[IMM5_HI]}}, ir[IMM5_HI:IMM5_LO]};
  assign sr1         = ir[SR1_HI:SR1_LO];
  assign sr2         = ir[SR2_HI:SR2_LO];
  // SR2 is only a real source for register-mode ADD/AND
  assign reads_sr2_s = ((opcode_s == OP_ADD) || (opcode_s == OP_AND)) && !imm_flag_s;
  assign alu_op_s    = is_alu_op(opcode_s);

`ifdef LC3_BYPASS_EN
  // Forward the not-yet-committed writeback over stale register-file data
  always_comb begin
    a_s     = d1;
    b_reg_s = d2;
    ready_s = reset_n;
    if (wr_q && (sr1 == dr_q)) begin
      a_s = din_q;
    end else begin
      a_s = d1;
    end
    if (wr_q && reads_sr2_s && (sr2 == dr_q)) begin
      b_reg_s = din_q;
    end else begin
      b_reg_s = d2;
    end
  end
`else
  // Stall one cycle while the register file still holds a stale source
  always_comb begin
    a_s     = d1;
    b_reg_s = d2;
    ready_s = reset_n;
    if (wr_q && in_valid &&
        ((sr1 == dr_q) || (reads_sr2_s && (sr2 == dr_q)))) begin
      ready_s = 1'b0;
    end else begin
      ready_s = reset_n;
    end
  end
`endif

  assign b_s      = imm_flag_s ? imm_sext_s : b_reg_s;
  assign in_ready = ready_s;
  assign accept_s = in_valid && ready_s;

  lc3_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode_i (opcode_s),
    .a_i      (a_s),
    .b_i      (b_s),
    .result_o (result_s),
    .nzp_o    (alu_nzp_s)
  );

  // Next-state for writeback port, condition codes and illegal pulse
  always_comb begin
    wr_d      = 1'b0;
    dr_d      = dr_q;
    din_d     = din_q;
    nzp_d     = nzp_q;
    illegal_d = 1'b0;
    if (accept_s && alu_op_s) begin
      wr_d  = 1'b1;
      dr_d  = dst_s;
      din_d = result_s;
      nzp_d = alu_nzp_s;
    end else if (accept_s) begin
      illegal_d = 1'b1;
    end else begin
      wr_d      = 1'b0;
      illegal_d = 1'b0;
    end
  end

  // State registers; reset drops any pending writeback
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q      <= 1'b0;
      dr_q      <= {RAW{1'b0}};
      din_q     <= {WIDTH{1'b0}};
      nzp_q     <= NZP_RESET;
      illegal_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      dr_q      <= dr_d;
      din_q     <= din_d;
      nzp_q     <= nzp_d;
      illegal_q <= illegal_d;
    end
  end

  assign wr      = wr_q;
  assign dr      = dr_q;
  assign din     = din_q;
  assign nzp     = nzp_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_lc3_execute.sv
// tb_lc3_execute: directed test of lc3_execute against a behavioural 8x16
// register file with combinational read and clocked write.
module tb_lc3_execute;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ir;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] d1;
  logic [15:0] d2;
  logic        wr;
  logic [2:0]  dr;
  logic [15:0] din;
  logic [2:0]  nzp;
  logic        illegal;

  // Register file model plus a side port used to preload values
  logic [15:0] rf [8];
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;
  int          wr_count = 0;

  int checks;
  int errors;
  int saved_count;

  lc3_execute dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ir       (ir),
    .sr1      (sr1),
    .sr2      (sr2),
    .d1       (d1),
    .d2       (d2),
    .wr       (wr),
    .dr       (dr),
    .din      (din),
    .nzp      (nzp),
    .illegal  (illegal)
  );

  assign d1 = rf[sr1];
  assign d2 = rf[sr2];

  always #5 clock = ~clock;

  // Register file write port; preload has priority
  always @(posedge clock) begin
    if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end else if (wr === 1'b1) begin
      rf[dr]   <= din;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] v);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = v;
    step();
    pl_en   = 1'b0;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clock    = 1'b0;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    ir       = 16'h1262;
    pl_en    = 1'b0;
    pl_addr  = 3'd0;
    pl_data  = 16'h0000;
    checks   = 0;
    errors   = 0;

    // Reset held with in_valid high while the register file is preloaded
    for (int i = 0; i < 8; i++) preload(i[2:0], 16'h0000);
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h00F0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_wr", wr, 1'b0);
    check_eq("rst_nzp", nzp, 3'b010);
    check_eq("rst_dr", dr, 3'd0);
    check_eq("rst_din", din, 16'h0000);
    check_eq("rst_illegal", illegal, 1'b0);
    check_eq("rst_no_writes", wr_count, 0);

    // ADD R1,R1,#2 with R1=5
    reset_n = 1'b1;
    #1;
    check_eq("add_imm_ready", in_ready, 1'b1);
    check_eq("add_imm_sr1", sr1, 3'd1);
    check_eq("add_imm_sr2", sr2, 3'd2);
    step();
    in_valid = 1'b0;
    check_eq("add_imm_wr", wr, 1'b1);
    check_eq("add_imm_dr", dr, 3'd1);
    check_eq("add_imm_din", din, 16'h0007);
    check_eq("add_imm_nzp", nzp, 3'b001);
    step();
    check_eq("idle_wr", wr, 1'b0);
    check_eq("idle_din_hold", din, 16'h0007);
    check_eq("rf_r1", rf[1], 16'h0007);

    // AND R3,R2,#0 then NOT R4,R2 back-to-back
    ir = 16'h56A0;
    in_valid = 1'b1;
    step();
    ir = 16'h98BF;
    #1;
    check_eq("and_wr", wr, 1'b1);
    check_eq("and_dr", dr, 3'd3);
    check_eq("and_din", din, 16'h0000);
    check_eq("and_nzp", nzp, 3'b010);
    check_eq("not_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check_eq("not_dr", dr, 3'd4);
    check_eq("not_din", din, 16'hFF0F);
    check_eq("not_nzp", nzp, 3'b100);
    step();

    // ADD R5,R2,R1 register mode: 0x00F0 + 7
    ir = 16'h1A81;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("add_reg_dr", dr, 3'd5);
    check_eq("add_reg_din", din, 16'h00F7);
    check_eq("add_reg_nzp", nzp, 3'b001);
    step();

    // ADD R6,R1,#-8: 7 - 8 wraps to 0xFFFF
    ir = 16'h1C78;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("add_neg_dr", dr, 3'd6);
    check_eq("add_neg_din", din, 16'hFFFF);
    check_eq("add_neg_nzp", nzp, 3'b100);
    step();

    // Hazard: ADD R1,R1,#1 then ADD R2,R1,R1 with R1=3
    preload(3'd1, 16'h0003);
    ir = 16'h1261;
    in_valid = 1'b1;
    #1;
    check_eq("haz_first_ready", in_ready, 1'b1);
    step();
    ir = 16'h1441;
    #1;
    check_eq("haz_first_din", din, 16'h0004);
`ifdef LC3_BYPASS_EN
    check_eq("haz_ready_bypass", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
`else
    check_eq("haz_stall", in_ready, 1'b0);
    step();
    check_eq("haz_bubble_wr", wr, 1'b0);
    check_eq("haz_resume", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
`endif
    check_eq("haz_wr", wr, 1'b1);
    check_eq("haz_dr", dr, 3'd2);
    check_eq("haz_din", din, 16'h0008);
    step();
    check_eq("rf_r2", rf[2], 16'h0008);

    // Immediate mode whose ir[2:0] matches pending DR: no stall
    ir = 16'h1261;
    in_valid = 1'b1;
    step();
    ir = 16'h16A1;
    #1;
    check_eq("imm_no_stall", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check_eq("imm_dr", dr, 3'd3);
    check_eq("imm_din", din, 16'h0009);
    check_eq("imm_nzp", nzp, 3'b001);
    step();

    // Illegal opcode (BR)
    ir = 16'h0E05;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("ill_pulse", illegal, 1'b1);
    check_eq("ill_wr", wr, 1'b0);
    check_eq("ill_nzp", nzp, 3'b001);
    check_eq("ill_din_hold", din, 16'h0009);
    step();
    check_eq("ill_clear", illegal, 1'b0);

    // Reset while an ADD is presented: nothing is written
    saved_count = wr_count;
    ir = 16'h1B61;
    in_valid = 1'b1;
    #1;
    check_eq("midrst_ready_before", in_ready, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_ready", in_ready, 1'b0);
    step();
    check_eq("midrst_wr0", wr, 1'b0);
    step();
    check_eq("midrst_wr1", wr, 1'b0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    step();
    check_eq("midrst_wr2", wr, 1'b0);
    check_eq("midrst_nzp", nzp, 3'b010);
    check_eq("midrst_din", din, 16'h0000);
    check_eq("midrst_rf_r5", rf[5], 16'h00F7);
    check_eq("midrst_count", wr_count, saved_count);
    check_eq("total_writes", wr_count, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
